// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - serialises NUM_REQ requesters onto the single framebuffer VRAM port
module vram_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT        = 1023
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_sel_i,
  input  logic [NUM_REQ-1:0]    req_wr_i,
  input  logic [4*NUM_REQ-1:0]  req_mask_i,
  input  logic [24*NUM_REQ-1:0] req_addr_i,
  input  logic [16*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ack_o,
  output logic [15:0]           req_data_o,
  output logic                  vram_sel_o,
  output logic                  vram_wr_o,
  output logic [3:0]            vram_mask_o,
  output logic [23:0]           vram_addr_o,
  output logic [15:0]           vram_data_o,
  input  logic [15:0]           vram_data_i,
  input  logic                  vram_ack_i,
  output logic                  busy_o,
  output logic [2:0]            grant_o,
  output logic                  timeout_o
);

  // Watchdog only needs to reach TIMEOUT-1: the abort fires on the cycle it holds that value.
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t               state, state_n;
  logic [2:0]           ptr, ptr_n;
  logic [WDW-1:0]       wd, wd_n;
  logic                 sel_n, wr_n, busy_n, to_n;
  logic [3:0]           mask_n;
  logic [23:0]          addr_n;
  logic [15:0]          data_n, rdata_n;
  logic [2:0]           grant_n;
  logic [NUM_REQ-1:0]   ack_n;

  logic [7:0]           req_pad;
  logic [2:0]           win, idx;
  logic                 found;

  // Winner selection: lowest index in fixed mode, otherwise first request after the rr pointer.
  always_comb begin
    req_pad = 8'(req_sel_i);
    win     = '0;
    idx     = '0;
    found   = 1'b0;
    if (FIXED_PRIORITY != 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_pad[i]) begin
          win   = 3'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = (int'(ptr) + i >= NUM_REQ) ? 3'(int'(ptr) + i - NUM_REQ) : 3'(int'(ptr) + i);
        if (!found && req_pad[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    wd_n    = wd;
    sel_n   = vram_sel_o;
    wr_n    = vram_wr_o;
    mask_n  = vram_mask_o;
    addr_n  = vram_addr_o;
    data_n  = vram_data_o;
    grant_n = grant_o;
    rdata_n = req_data_o;
    ack_n   = '0;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          wd_n    = '0;
          sel_n   = 1'b1;
          wr_n    = req_wr_i[win];
          mask_n  = req_mask_i[4*int'(win) +: 4];
          addr_n  = req_addr_i[24*int'(win) +: 24];
          data_n  = req_data_i[16*int'(win) +: 16];
          grant_n = win;
        end
      end
      BUSY: begin
        // An abort looks exactly like a completion to the requester, except for zero data.
        if (vram_ack_i || wd == WD_LAST) begin
          state_n = RELEASE;
          sel_n   = 1'b0;
          ack_n   = NUM_REQ'(1) << grant_o;
          ptr_n   = grant_o;
          rdata_n = vram_ack_i ? vram_data_i : 16'h0000;
          to_n    = !vram_ack_i;
        end else begin
          wd_n = wd + WDW'(1);
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= IDLE;
      ptr         <= 3'(NUM_REQ - 1);
      wd          <= '0;
      vram_sel_o  <= 1'b0;
      vram_wr_o   <= 1'b0;
      vram_mask_o <= '0;
      vram_addr_o <= '0;
      vram_data_o <= '0;
      grant_o     <= '0;
      req_ack_o   <= '0;
      req_data_o  <= '0;
      timeout_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      wd          <= wd_n;
      vram_sel_o  <= sel_n;
      vram_wr_o   <= wr_n;
      vram_mask_o <= mask_n;
      vram_addr_o <= addr_n;
      vram_data_o <= data_n;
      grant_o     <= grant_n;
      req_ack_o   <= ack_n;
      req_data_o  <= rdata_n;
      timeout_o   <= to_n;
      busy_o      <= busy_n;
    end
  end

endmodule
